pwm_gen: RTL
============

# pwm_gen

PWM generator, the transmit side of the duty-cycle measurement path. It produces a PWM waveform whose high time per period equals a programmed duty count. Duty and period are double-buffered, so they change only on period boundaries. It drives motor/LED loads and provides the loopback stimulus for the duty measurement block, whose reading must equal the programmed duty.

## Interface
- WIDTH, 10: width of duty, period and internal counter; matches the 10-bit duty measurement result.
- RST_PERIOD, 1023: active period loaded at reset.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- en  input  1  run request; level-sensitive.
- cfg_wr  input  1  single-cycle strobe; captures duty_in/period_in into shadow.
- duty_in  input  WIDTH  requested high cycles per period.
- period_in  input  WIDTH  requested period length in clk cycles.
- cfg_pend  output  1  shadow holds values not yet applied.
- PWM  output  1  registered PWM output.
- prd_start  output  1  high for the first clk cycle of every period.
- busy  output  1  state != IDLE.

## Operation
- States:
  - IDLE: counter 0, PWM 0.
  - RUN: periods repeat.
  - DRAIN: en dropped, current period finishes.
- Transitions:
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0.
  - DRAIN -> RUN when en=1; no gap, counter continues.
  - DRAIN -> IDLE at period wrap.
- Counter cnt runs 0 .. period_act-1. At wrap it returns to 0.
- Shadow and active registers:
  - Shadow is copied to active (duty_act, period_act) on entry to RUN from IDLE, and at each wrap while cfg_pend=1. cfg_pend then clears.
  - cfg_wr sets cfg_pend. Repeated writes before apply: last write wins.
  - cfg_wr in the same cycle as an apply: the new value goes to shadow and cfg_pend stays 1, applied at the next boundary.
- PWM = 1 exactly while cnt < duty_act, so each period has duty_act high cycles followed by period_act-duty_act low cycles.
- Clamping:
  - period_in < 2 is stored as 2.
  - duty_act >= period_act: PWM constantly high. Note: the measurement block sees no rising edge in that case.
  - duty_act = 0: PWM constantly low.
- Reset values: PWM=0, prd_start=0, busy=0, cfg_pend=0, cnt=0, duty_act=0, period_act=RST_PERIOD, shadow duty=0, shadow period=RST_PERIOD, state IDLE.

## Timing
- PWM, prd_start, cnt and state are all registered. PWM is computed from next-state cnt/duty so that it is cycle-aligned with cnt.
- Start latency: en sampled high at edge k in IDLE. After edge k: cnt=0, prd_start=1, and PWM=1 if duty_act>0, where duty_act is the freshly applied value.
- prd_start is high in every cycle where cnt=0 and state is RUN or DRAIN. It is low in IDLE.
- Stop: en sampled low at edge k during RUN. The remaining cycles of the current period are output unchanged. After the wrap edge: PWM=0 and busy=0.
- Each rising edge of PWM coincides with prd_start, except when duty_act=0.
- Reset mid-period: PWM drops to 0 asynchronously, any pending config is lost, and the block restarts from IDLE.

## Structure
- Shared package pwm_pkg holds:
  - state enum {IDLE, RUN, DRAIN};
  - default WIDTH;
  - MIN_PERIOD=2;
  - RST_PERIOD.
- One natural sub-module, pwm_cfg_shadow: shadow regs, cfg_pend, clamp, and apply logic. It takes an apply strobe and outputs the active values.
- The FSM, counter and output register sit in the top level.

## Test plan
- Reset, cfg duty=3 period=10, en=1 -> PWM pattern of 3 high / 7 low, repeating; prd_start every 10 cycles; loopback duty_meas reads 3.
- While running with duty=3 period=10, cfg_wr duty=6 mid-period -> current period keeps 3; next period shows 6 high; cfg_pend falls at the wrap edge.
- Two cfg_wr (duty=2, then duty=8) in one period -> only 8 is applied; 2 never appears.
- en low at cnt=4 with duty=3 period=10 -> cycles 4..9 output low, then busy=0 and PWM stays 0. A separate run with en reasserted at cnt=7 -> no gap and no extra prd_start.
- duty=0 -> PWM never high. duty=15 with period=10 -> PWM constantly high. period_in=1 -> effective period 2.
- rst asserted while PWM=1 at cnt=1 -> PWM=0 immediately; all outputs at reset values; after release, en restarts with duty_act=0 and period RST_PERIOD.

Source files
------------

// File: rtl/pwm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_pkg : shared types and constants for the PWM generator  rev 1.0 |
// +--------------------------------------------------------------------+
package pwm_pkg;

  localparam int WIDTH      = 10;
  localparam int MIN_PERIOD = 2;
  localparam int RST_PERIOD = 1023;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_cfg_shadow.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_cfg_shadow : double-buffered duty/period config          rev 1.0 |
// +--------------------------------------------------------------------+
module pwm_cfg_shadow #(
  parameter int WIDTH      = pwm_pkg::WIDTH,
  parameter int RST_PERIOD = pwm_pkg::RST_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [WIDTH-1:0] duty_in,
  input  logic [WIDTH-1:0] period_in,
  input  logic             apply,
  output logic             cfg_pend,
  output logic [WIDTH-1:0] duty_act,
  output logic [WIDTH-1:0] period_act,
  output logic [WIDTH-1:0] duty_nxt
);
  import pwm_pkg::*;

  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] RST_P = WIDTH'(RST_PERIOD);

  logic [WIDTH-1:0] shadow_duty;
  logic [WIDTH-1:0] shadow_period;
  logic [WIDTH-1:0] period_clamped;

  assign period_clamped = (period_in < MIN_P) ? MIN_P : period_in;

  // Duty that becomes active at this edge, so the output register can use it immediately
  assign duty_nxt = apply ? shadow_duty : duty_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_duty   <= '0;
      shadow_period <= RST_P;
      duty_act      <= '0;
      period_act    <= RST_P;
      cfg_pend      <= 1'b0;
    end else begin
      if (cfg_wr) begin
        shadow_duty   <= duty_in;
        shadow_period <= period_clamped;
      end
      if (apply) begin
        duty_act   <= shadow_duty;
        period_act <= shadow_period;
      end
      // A write coinciding with an apply stays pending for the next boundary
      if (cfg_wr) begin
        cfg_pend <= 1'b1;
      end else if (apply) begin
        cfg_pend <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_gen : PWM generator with period-aligned config updates   rev 1.0 |
// +--------------------------------------------------------------------+
module pwm_gen #(
  parameter int WIDTH      = pwm_pkg::WIDTH,
  parameter int RST_PERIOD = pwm_pkg::RST_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic [WIDTH-1:0] duty_in,
  input  logic [WIDTH-1:0] period_in,
  output logic             cfg_pend,
  output logic             PWM,
  output logic             prd_start,
  output logic             busy
);
  import pwm_pkg::*;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] duty_act;
  logic [WIDTH-1:0] period_act;
  logic [WIDTH-1:0] duty_nxt;
  logic             wrap;
  logic             apply;

  assign wrap    = (cnt == period_act - WIDTH'(1));
  assign cnt_nxt = wrap ? '0 : cnt + WIDTH'(1);
  assign apply   = (state == IDLE) ? en : (wrap && cfg_pend);

  pwm_cfg_shadow #(
    .WIDTH      (WIDTH),
    .RST_PERIOD (RST_PERIOD)
  ) u_cfg (
    .clk        (clk),
    .rst        (rst),
    .cfg_wr     (cfg_wr),
    .duty_in    (duty_in),
    .period_in  (period_in),
    .apply      (apply),
    .cfg_pend   (cfg_pend),
    .duty_act   (duty_act),
    .period_act (period_act),
    .duty_nxt   (duty_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      PWM       <= 1'b0;
      prd_start <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) begin
            state     <= RUN;
            busy      <= 1'b1;
            prd_start <= 1'b1;
            PWM       <= (duty_nxt != '0);
          end else begin
            busy      <= 1'b0;
            prd_start <= 1'b0;
            PWM       <= 1'b0;
          end
        end
        default: begin
          // RUN and DRAIN differ only in whether the upcoming wrap ends the run
          if (wrap && !en) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            prd_start <= 1'b0;
            PWM       <= 1'b0;
          end else begin
            state     <= en ? RUN : DRAIN;
            busy      <= 1'b1;
            cnt       <= cnt_nxt;
            prd_start <= wrap;
            PWM       <= (cnt_nxt < duty_nxt);
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
